// File: rtl/half_adder_if.sv
// Operand/result bundle for half_adder: master drives operands, slave returns
// the combinational and registered results.
interface half_adder_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             in_valid;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic             out_valid;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output a, b, in_valid,
    input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );

  modport slave (
    input  a, b, in_valid,
    output sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );
endinterface

// File: rtl/half_adder.sv
// Per-lane half adder with a zero-latency view and a one-cycle registered view.
// Define HA_CARRY_CNT_EN to build the saturating carry-event counter.
module half_adder #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  half_adder_if.slave bus
);

  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH-1:0] carry_comb;

  logic [WIDTH-1:0] res_sum_d,   res_sum_q;
  logic [WIDTH-1:0] res_carry_d, res_carry_q;
  logic             valid_d,     valid_q;

  // Lanes are independent: plain bitwise operators, no inter-lane carry.
  assign sum_comb   = bus.a ^ bus.b;
  assign carry_comb = bus.a & bus.b;

  assign bus.sum   = sum_comb;
  assign bus.carry = carry_comb;

  always_comb begin
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    valid_d     = 1'b0;
    if (bus.in_valid) begin
      res_sum_d   = sum_comb;
      res_carry_d = carry_comb;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_sum_q   <= '0;
      res_carry_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.sum_q     = res_sum_q;
  assign bus.carry_q   = res_carry_q;
  assign bus.out_valid = valid_q;

`ifdef HA_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             carry_event;

  assign carry_event = bus.in_valid && (|carry_comb);

  // Saturate at all-ones rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (carry_event && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.carry_cnt = cnt_q;
`else
  assign bus.carry_cnt = '0;
`endif

  // A registered result only ever follows an accepted, non-reset edge.
  a_valid_src: assert property (@(posedge clk) valid_q |-> $past(bus.in_valid && rst_n));

  // Idle edges out of reset must leave the result registers untouched.
  a_hold: assert property (@(posedge clk)
    ($past(rst_n) && !$past(bus.in_valid) && rst_n) |->
      ($stable(res_sum_q) && $stable(res_carry_q)));

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a lane-arithmetic reference model checked every
// cycle, plus hand-computed literal expectations.
module tb_half_adder;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  half_adder_if #(.WIDTH(W), .CNT_W(CW)) bus4 ();
  half_adder_if #(.WIDTH(1), .CNT_W(CW)) bus1 ();

  half_adder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  half_adder #(.WIDTH(1), .CNT_W(CW)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lane sum/carry from integer addition of the two bits.
  logic [W-1:0] m_sum, m_carry;
  logic         m_valid;
  int           m_cnt;
  bit           m_known = 1'b0;

  always @(posedge clk) begin
    int s;
    bit any;
    if (!rst_n) begin
      m_sum = '0; m_carry = '0; m_valid = 1'b0; m_cnt = 0; m_known = 1'b1;
    end else if (bus4.in_valid) begin
      any = 1'b0;
      for (int i = 0; i < W; i++) begin
        s = int'(bus4.a[i]) + int'(bus4.b[i]);
        m_sum[i]   = (s % 2) == 1;
        m_carry[i] = (s / 2) == 1;
        if (s == 2) any = 1'b1;
      end
      m_valid = 1'b1;
      if (any && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end else begin
      m_valid = 1'b0;
    end
  end

  function automatic int exp_cnt(input int c);
`ifdef HA_CARRY_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  // Compare process: every negedge, all meaningful outputs vs. the model.
  always @(negedge clk) begin
    logic [W-1:0] es, ec;
    int s;
    for (int i = 0; i < W; i++) begin
      s = int'(bus4.a[i]) + int'(bus4.b[i]);
      es[i] = (s % 2) == 1;
      ec[i] = (s / 2) == 1;
    end
    chk("sum", 32'(bus4.sum), 32'(es));
    chk("carry", 32'(bus4.carry), 32'(ec));
    s = int'(bus1.a[0]) + int'(bus1.b[0]);
    chk("w1_sum", 32'(bus1.sum), 32'(s % 2));
    chk("w1_carry", 32'(bus1.carry), 32'(s / 2));
    if (m_known) begin
      chk("sum_q", 32'(bus4.sum_q), 32'(m_sum));
      chk("carry_q", 32'(bus4.carry_q), 32'(m_carry));
      chk("out_valid", 32'(bus4.out_valid), 32'(m_valid));
      chk("carry_cnt", 32'(bus4.carry_cnt), 32'(exp_cnt(m_cnt)));
      chk("w1_out_valid", 32'(bus1.out_valid), 32'(0));
      chk("w1_sum_q", 32'(bus1.sum_q), 32'(0));
      chk("w1_carry_q", 32'(bus1.carry_q), 32'(0));
      chk("w1_carry_cnt", 32'(bus1.carry_cnt), 32'(0));
    end
  end

  task automatic step(input logic r, input logic v, input logic [W-1:0] aa,
                      input logic [W-1:0] bb);
    rst_n         = r;
    bus4.in_valid = v;
    bus4.a        = aa;
    bus4.b        = bb;
    @(posedge clk);
    #2;
  endtask

  task automatic lit_regs(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                          input logic v, input int cnt);
    chk({tag, "_sum_q"}, 32'(bus4.sum_q), 32'(s));
    chk({tag, "_carry_q"}, 32'(bus4.carry_q), 32'(c));
    chk({tag, "_out_valid"}, 32'(bus4.out_valid), 32'(v));
    chk({tag, "_carry_cnt"}, 32'(bus4.carry_cnt), 32'(exp_cnt(cnt)));
  endtask

  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  initial begin
    logic [3:0] tt_s, tt_c;
    int cnt_seq [5];
    vec_t vecs [6];
    tt_s = 4'b0110;  // index {a,b}: 00,01,10,11
    tt_c = 4'b1000;
    cnt_seq = '{1, 2, 3, 3, 3};
    vecs = '{'{1'b1, 4'h3, 4'h5}, '{1'b1, 4'h0, 4'h0}, '{1'b0, 4'hF, 4'hF},
             '{1'b1, 4'h9, 4'h6}, '{1'b1, 4'hF, 4'h0}, '{1'b1, 4'h7, 4'h7}};

    bus1.in_valid = 1'b0;
    bus1.a = 1'b1;
    bus1.b = 1'b1;

    // Reset held over two valid edges with all operands set.
    step(1'b0, 1'b1, 4'hF, 4'hF);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    lit_regs("rst", 4'h0, 4'h0, 1'b0, 0);

    // Truth table on the single-lane instance.
    for (int k = 0; k < 4; k++) begin
      bus1.a = 1'((k >> 1) & 1);
      bus1.b = 1'(k & 1);
      #5;
      chk("tt_sum", 32'(bus1.sum), 32'(tt_s[k]));
      chk("tt_carry", 32'(bus1.carry), 32'(tt_c[k]));
      #5;
    end

    // Single valid edge, then an idle edge with new operands: registers hold.
    step(1'b1, 1'b1, 4'hF, 4'hF);
    lit_regs("cap", 4'h0, 4'hF, 1'b1, 1);
    step(1'b1, 1'b0, 4'h5, 4'h3);
    lit_regs("hold", 4'h0, 4'hF, 1'b0, 1);

    // Independent lanes.
    rst_n = 1'b1;
    bus4.in_valid = 1'b1;
    bus4.a = 4'b1100;
    bus4.b = 4'b1010;
    #1;
    chk("lanes_sum", 32'(bus4.sum), 32'(4'b0110));
    chk("lanes_carry", 32'(bus4.carry), 32'(4'b1000));
    @(posedge clk);
    #2;
    lit_regs("lanes", 4'b0110, 4'b1000, 1'b1, 2);

    // Counter saturation from a fresh reset.
    step(1'b0, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 4'h1, 4'h1);
      chk("sat_cnt", 32'(bus4.carry_cnt), 32'(exp_cnt(cnt_seq[k])));
    end

    // Mixed directed traffic, checked by the model.
    for (int k = 0; k < 6; k++) step(1'b1, vecs[k].v, vecs[k].a, vecs[k].b);

    // Reset on a valid edge mid-stream discards that capture.
    step(1'b1, 1'b1, 4'h5, 4'h7);
    lit_regs("pre_rst", 4'h2, 4'h5, 1'b1, 3);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    lit_regs("mid_rst", 4'h0, 4'h0, 1'b0, 0);
    step(1'b1, 1'b1, 4'h2, 4'h3);
    lit_regs("post_rst", 4'h1, 4'h2, 1'b1, 1);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
